// File: rtl/clb_pkg.sv
// Shared CLB configuration constants and helpers for the configurable logic blocks.
package clb_pkg;

    localparam int unsigned LUT_INPUTS   = 4;
    localparam int unsigned LUT_MEM_SIZE = 16;
    localparam int unsigned CFG_WIDTH    = 1;

    // Number of enabled config clocks needed to fill one block's storage.
    function automatic int unsigned loading_cycles(input int unsigned mem_size,
                                                   input int unsigned cfg_width);
        return mem_size / cfg_width;
    endfunction

endpackage

// File: rtl/cfg_shift_reg.sv
// Configuration shift chain: DEPTH words of WIDTH bits, shifting toward the MSBs.
module cfg_shift_reg #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [WIDTH-1:0]         shift_in,
    output logic [WIDTH-1:0]         shift_out,
    output logic [WIDTH*DEPTH-1:0]   contents
);

    localparam int unsigned TOTAL = WIDTH * DEPTH;

    logic [TOTAL-1:0] regs;

    // A single-word chain has no lower slice to concatenate, so it loads directly.
    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    regs <= '0;
                end else if (en) begin
                    regs <= shift_in;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    regs <= '0;
                end else if (en) begin
                    regs <= {regs[TOTAL-WIDTH-1:0], shift_in};
                end
            end
        end
    endgenerate

    assign shift_out = regs[TOTAL-1 -: WIDTH];
    assign contents  = regs;

endmodule

// File: rtl/cfg_lut.sv
// K-input look-up table whose truth table is loaded through a daisy-chained config shift chain.
module cfg_lut
    import clb_pkg::*;
#(
    parameter int unsigned INPUTS       = LUT_INPUTS,
    parameter int unsigned MEM_SIZE     = LUT_MEM_SIZE,
    parameter int unsigned CONFIG_WIDTH = CFG_WIDTH
) (
    input  logic                    config_clk,
    input  logic                    config_rst_n,
    input  logic [INPUTS-1:0]       addr,
    output logic                    out,
    input  logic                    config_en,
    input  logic [CONFIG_WIDTH-1:0] config_in,
    output logic [CONFIG_WIDTH-1:0] config_out
);

    generate
        if ((MEM_SIZE != (2 ** INPUTS)) || ((MEM_SIZE % CONFIG_WIDTH) != 0)) begin : g_bad_params
            $fatal(1, "cfg_lut: MEM_SIZE must be 2**INPUTS and a multiple of CONFIG_WIDTH");
        end
    endgenerate

    logic [MEM_SIZE-1:0] mem;

    cfg_shift_reg #(
        .WIDTH (CONFIG_WIDTH),
        .DEPTH (loading_cycles(MEM_SIZE, CONFIG_WIDTH))
    ) u_chain (
        .clk       (config_clk),
        .rst_n     (config_rst_n),
        .en        (config_en),
        .shift_in  (config_in),
        .shift_out (config_out),
        .contents  (mem)
    );

    // Read path is purely combinational; it follows partial contents while loading.
    assign out = mem[addr];

endmodule

// File: tb/tb_cfg_lut.sv
// Self-checking bench for cfg_lut: directed table, multi-cycle sequences and a randomized model comparison.
module tb_cfg_lut;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       en1;
    logic [0:0] in1;
    logic [3:0] addr1;
    logic       out1;
    logic [0:0] cout1;

    logic       enc;
    logic [0:0] inc;
    logic [3:0] addr_near, addr_far;
    logic       out_near, out_far;
    logic [0:0] link, cout_far;

    logic       en4;
    logic [3:0] in4;
    logic [3:0] addr4;
    logic       out4;
    logic [3:0] cout4;

    cfg_lut #(.INPUTS(4), .MEM_SIZE(16), .CONFIG_WIDTH(1)) u_lut (
        .config_clk(clk), .config_rst_n(rst_n), .addr(addr1), .out(out1),
        .config_en(en1), .config_in(in1), .config_out(cout1));

    cfg_lut #(.INPUTS(4), .MEM_SIZE(16), .CONFIG_WIDTH(1)) u_near (
        .config_clk(clk), .config_rst_n(rst_n), .addr(addr_near), .out(out_near),
        .config_en(enc), .config_in(inc), .config_out(link));

    cfg_lut #(.INPUTS(4), .MEM_SIZE(16), .CONFIG_WIDTH(1)) u_far (
        .config_clk(clk), .config_rst_n(rst_n), .addr(addr_far), .out(out_far),
        .config_en(enc), .config_in(link), .config_out(cout_far));

    cfg_lut #(.INPUTS(4), .MEM_SIZE(16), .CONFIG_WIDTH(4)) u_w4 (
        .config_clk(clk), .config_rst_n(rst_n), .addr(addr4), .out(out4),
        .config_en(en4), .config_in(in4), .config_out(cout4));

    int checks   = 0;
    int failures = 0;

    // Every word accepted since the last reset, oldest first.
    int q1[$];
    int qc[$];
    int q4[$];

    typedef struct {
        logic [15:0] pattern;
        logic [3:0]  addr;
        logic        exp;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Truth table as the most recent words seen: newest word in the LSBs,
    // skipping the newest `skip` words (those still sitting in nearer chain stages).
    function automatic logic [15:0] model_mem(input int q[$], input int w, input int skip);
        logic [15:0] m;
        int n;
        int idx;
        int wv;
        m = '0;
        n = 16 / w;
        for (int j = 0; j < n; j++) begin
            idx = q.size() - 1 - skip - j;
            if (idx >= 0) begin
                wv = q[idx];
                for (int b = 0; b < w; b++) m[j*w + b] = wv[b];
            end
        end
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        q1.delete();
        qc.delete();
        q4.delete();
    endtask

    task automatic shift1(input logic b);
        in1 = b;
        en1 = 1'b1;
        tick();
        q1.push_back(int'(b));
        en1 = 1'b0;
    endtask

    task automatic load1(input logic [15:0] p);
        for (int i = 15; i >= 0; i--) shift1(p[i]);
    endtask

    task automatic shiftc(input logic b);
        inc = b;
        enc = 1'b1;
        tick();
        qc.push_back(int'(b));
        enc = 1'b0;
    endtask

    task automatic shift4(input logic [3:0] nib);
        in4 = nib;
        en4 = 1'b1;
        tick();
        q4.push_back(int'(nib));
        en4 = 1'b0;
    endtask

    task automatic sweep(input int which, input string name, input logic [15:0] exp);
        logic got;
        for (int a = 0; a < 16; a++) begin
            case (which)
                0: addr1     = 4'(a);
                1: addr_near = 4'(a);
                2: addr_far  = 4'(a);
                default: addr4 = 4'(a);
            endcase
            #1;
            case (which)
                0: got = out1;
                1: got = out_near;
                2: got = out_far;
                default: got = out4;
            endcase
            check($sformatf("%s[%0d]", name, a), 32'(got), 32'(exp[a]));
        end
    endtask

    initial begin
        logic [15:0] m1, mn, mf, m4;
        logic [31:0] chain_stream;

        rst_n = 1'b0;
        en1 = 1'b0; in1 = '0; addr1 = '0;
        enc = 1'b0; inc = '0; addr_near = '0; addr_far = '0;
        en4 = 1'b0; in4 = '0; addr4 = '0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset clears a fully loaded table and wins over a pending enable.
        load1(16'hFFFF);
        sweep(0, "preload_ffff", 16'hFFFF);
        en1 = 1'b1;
        in1 = 1'b1;
        do_reset();
        en1 = 1'b0;
        sweep(0, "reset_out", 16'h0000);
        check("reset_config_out", 32'(cout1), 32'd0);

        tbl[0] = '{16'h8000, 4'hF, 1'b1};
        tbl[1] = '{16'h8000, 4'h0, 1'b0};
        tbl[2] = '{16'h8000, 4'h7, 1'b0};
        tbl[3] = '{16'h8000, 4'hE, 1'b0};
        tbl[4] = '{16'hACE1, 4'h0, 1'b1};
        tbl[5] = '{16'hACE1, 4'h1, 1'b0};
        tbl[6] = '{16'hACE1, 4'h5, 1'b1};
        tbl[7] = '{16'hACE1, 4'hF, 1'b1};
        tbl[8] = '{16'h6996, 4'h7, 1'b1};
        tbl[9] = '{16'h6996, 4'h3, 1'b0};

        for (int i = 0; i < 10; i++) begin
            if (i == 0 || tbl[i].pattern != tbl[i-1].pattern) begin
                do_reset();
                load1(tbl[i].pattern);
                if (tbl[i].pattern == 16'h8000)
                    check("and4_config_out", 32'(cout1), 32'd1);
                if (tbl[i].pattern == 16'h6996) begin
                    for (int c = 0; c < 20; c++) begin
                        in1 = 1'($urandom_range(0, 1));
                        tick();
                    end
                    sweep(0, "hold", model_mem(q1, 1, 0));
                end
            end
            addr1 = tbl[i].addr;
            #1;
            check($sformatf("table[%0d]", i), 32'(out1), 32'(tbl[i].exp));
        end

        do_reset();
        load1(16'hACE1);
        sweep(0, "ace1_sweep", model_mem(q1, 1, 0));

        // Two-stage chain: far LUT's words go first.
        do_reset();
        chain_stream = {16'h8000, 16'hFFFE};
        for (int i = 31; i >= 0; i--) shiftc(chain_stream[i]);
        addr_far = 4'hF;
        addr_near = 4'h0;
        #1;
        check("chain_far_F", 32'(out_far), 32'd1);
        check("chain_near_0", 32'(out_near), 32'd0);
        addr_near = 4'h1;
        #1;
        check("chain_near_1", 32'(out_near), 32'd1);
        sweep(1, "chain_near", model_mem(qc, 1, 0));
        sweep(2, "chain_far", model_mem(qc, 1, 16));
        check("chain_config_out", 32'(cout_far), 32'd1);

        // Nibble-wide chain fills in exactly four enables.
        do_reset();
        shift4(4'hA);
        shift4(4'hC);
        shift4(4'hE);
        check("w4_out_before_last", 32'(cout4), 32'h0);
        shift4(4'h1);
        check("w4_config_out", 32'(cout4), 32'hA);
        sweep(3, "w4_ace1", 16'hACE1);

        // Randomized run against the word-history model, with occasional resets.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
            en1 = 1'($urandom_range(0, 1));
            in1 = 1'($urandom_range(0, 1));
            enc = 1'($urandom_range(0, 1));
            inc = 1'($urandom_range(0, 1));
            en4 = 1'($urandom_range(0, 1));
            in4 = 4'($urandom_range(0, 15));
            tick();
            if (!rst_n) begin
                q1.delete();
                qc.delete();
                q4.delete();
            end else begin
                if (en1) q1.push_back(int'(in1));
                if (enc) qc.push_back(int'(inc));
                if (en4) q4.push_back(int'(in4));
            end
            rst_n = 1'b1;
            addr1 = 4'($urandom_range(0, 15));
            addr_near = 4'($urandom_range(0, 15));
            addr_far = 4'($urandom_range(0, 15));
            addr4 = 4'($urandom_range(0, 15));
            #1;
            m1 = model_mem(q1, 1, 0);
            mn = model_mem(qc, 1, 0);
            mf = model_mem(qc, 1, 16);
            m4 = model_mem(q4, 4, 0);
            check("rand_out1", 32'(out1), 32'(m1[addr1]));
            check("rand_cout1", 32'(cout1), 32'(m1[15]));
            check("rand_near", 32'(out_near), 32'(mn[addr_near]));
            check("rand_far", 32'(out_far), 32'(mf[addr_far]));
            check("rand_cout_far", 32'(cout_far), 32'(mf[15]));
            check("rand_out4", 32'(out4), 32'(m4[addr4]));
            check("rand_cout4", 32'(cout4), 32'(m4[15:12]));
        end

        en1 = 1'b0;
        enc = 1'b0;
        en4 = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
